pll_rst_seq: RTL and testbench

- Reset sequencer directly downstream of the PLL_FREQ clock generator.
- Clocked by the free-running 25 MHz reference (the PLL input clock). Synchronises and filters the PLL LOCK output.
- Releases staged synchronous resets for the core domain (CLKOP, 150 MHz) and peripheral domain (CLKOS, 100 MHz).
- Tracks lock-loss events and lock-acquisition timeout.

---
 rtl/pll_rst_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the PLL: filters the synchronised LOCK, then releases the
// core and peripheral resets in stages. It also tracks lock losses and lock-acquisition timeout.
module pll_rst_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILT   = 1024,
   parameter int CORE_DLY    = 64,
   parameter int PERIPH_DLY  = 256,
   parameter int TIMEOUT     = 250000,
   parameter int CNT_W       = 8
) (
   input  logic             CLKI,
   input  logic             RSTN,
   input  logic             LOCK,
   input  logic             SOFT_RST,
   output logic             RST_CORE_N,
   output logic             RST_PERIPH_N,
   output logic             READY,
   output logic             TIMEOUT_FLAG,
   output logic [CNT_W-1:0] LOSS_CNT,
   output logic [2:0]       STATE
);

   localparam int MAX_FC  = (LOCK_FILT > CORE_DLY) ? LOCK_FILT : CORE_DLY;
   localparam int MAX_PT  = (PERIPH_DLY > TIMEOUT) ? PERIPH_DLY : TIMEOUT;
   localparam int MAX_ALL = (MAX_FC > MAX_PT) ? MAX_FC : MAX_PT;
   localparam int CW      = $clog2(MAX_ALL) + 1;

   localparam logic [CW-1:0]    ZERO_C      = {CW{1'b0}};
   localparam logic [CW-1:0]    ONE_C       = CW'(1);
   localparam logic [CW-1:0]    FILT_C      = CW'(LOCK_FILT);
   localparam logic [CW-1:0]    CORE_LAST   = CW'(CORE_DLY - 1);
   localparam logic [CW-1:0]    PERIPH_LAST = CW'(PERIPH_DLY - 1);
   localparam logic [CW-1:0]    TMO_C       = CW'(TIMEOUT);
   localparam logic [CNT_W-1:0] LOSS_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LOSS_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      WAIT_LOCK  = 3'd0,
      FILTER     = 3'd1,
      REL_CORE   = 3'd2,
      REL_PERIPH = 3'd3,
      RUN        = 3'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   lock_s;
   logic                   loss_s;
   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [CW-1:0]          dly_r;
   logic [CW-1:0]          dly_nxt_s;
   logic [CW-1:0]          tmo_r;
   logic [CW-1:0]          tmo_nxt_s;
   logic                   tflag_r;
   logic                   tflag_nxt_s;
   logic [CNT_W-1:0]       loss_r;
   logic [CNT_W-1:0]       loss_nxt_s;
   logic                   core_n_r;
   logic                   periph_n_r;
   logic                   ready_r;
   logic                   core_n_nxt_s;
   logic                   periph_n_nxt_s;
   logic                   ready_nxt_s;

   // LOCK synchroniser; the last stage is the only path from LOCK into the logic
   always_ff @(posedge CLKI or negedge RSTN) begin
      if (!RSTN) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], LOCK};
      end
   end

   assign lock_s = sync_r[SYNC_STAGES-1];
   assign loss_s = ~lock_s & ((state_r == REL_CORE) | (state_r == REL_PERIPH) | (state_r == RUN));

   // State and delay counter registers
   always_ff @(posedge CLKI or negedge RSTN) begin
      if (!RSTN) begin
         state_r <= WAIT_LOCK;
         dly_r   <= ZERO_C;
      end else begin
         state_r <= state_nxt_s;
         dly_r   <= dly_nxt_s;
      end
   end

   // Next-state and delay counter; SOFT_RST overrides every transition
   always_comb begin
      state_nxt_s = state_r;
      dly_nxt_s   = dly_r;
      if (SOFT_RST) begin
         state_nxt_s = WAIT_LOCK;
         dly_nxt_s   = ZERO_C;
      end else begin
         case (state_r)
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt_s = FILTER;
                  dly_nxt_s   = ONE_C;
               end else begin
                  dly_nxt_s   = ZERO_C;
               end
            end
            FILTER: begin
               if (!lock_s) begin
                  state_nxt_s = WAIT_LOCK;
                  dly_nxt_s   = ZERO_C;
               end else if (dly_r == FILT_C) begin
                  state_nxt_s = REL_CORE;
                  dly_nxt_s   = ZERO_C;
               end else begin
                  dly_nxt_s   = dly_r + ONE_C;
               end
            end
            REL_CORE: begin
               if (!lock_s) begin
                  state_nxt_s = WAIT_LOCK;
                  dly_nxt_s   = ZERO_C;
               end else if (dly_r == CORE_LAST) begin
                  state_nxt_s = REL_PERIPH;
                  dly_nxt_s   = ZERO_C;
               end else begin
                  dly_nxt_s   = dly_r + ONE_C;
               end
            end
            REL_PERIPH: begin
               if (!lock_s) begin
                  state_nxt_s = WAIT_LOCK;
                  dly_nxt_s   = ZERO_C;
               end else if (dly_r == PERIPH_LAST) begin
                  state_nxt_s = RUN;
                  dly_nxt_s   = ZERO_C;
               end else begin
                  dly_nxt_s   = dly_r + ONE_C;
               end
            end
            RUN: begin
               dly_nxt_s = ZERO_C;
               if (!lock_s) begin
                  state_nxt_s = WAIT_LOCK;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            default: begin
               state_nxt_s = WAIT_LOCK;
               dly_nxt_s   = ZERO_C;
            end
         endcase
      end
   end

   // Timeout counter: runs while hunting for lock and survives filter glitches
   always_comb begin
      tmo_nxt_s   = tmo_r;
      tflag_nxt_s = tflag_r;
      if (SOFT_RST) begin
         tmo_nxt_s   = ZERO_C;
         tflag_nxt_s = 1'b0;
      end else if ((state_r == FILTER) && (state_nxt_s == REL_CORE)) begin
         tmo_nxt_s   = ZERO_C;
      end else if (((state_r == WAIT_LOCK) || (state_r == FILTER)) && (tmo_r != TMO_C)) begin
         tmo_nxt_s   = tmo_r + ONE_C;
         if (tmo_r == (TMO_C - ONE_C)) begin
            tflag_nxt_s = 1'b1;
         end else begin
            tflag_nxt_s = tflag_r;
         end
      end else begin
         tmo_nxt_s   = tmo_r;
      end
   end

   // Saturating lock-loss counter; a loss coincident with SOFT_RST still counts once
   always_comb begin
      loss_nxt_s = loss_r;
      if (loss_s && (loss_r != LOSS_MAX)) begin
         loss_nxt_s = loss_r + LOSS_ONE;
      end else begin
         loss_nxt_s = loss_r;
      end
   end

   // Output decode from the next state so the registered outputs change with the state
   always_comb begin
      core_n_nxt_s   = 1'b0;
      periph_n_nxt_s = 1'b0;
      ready_nxt_s    = 1'b0;
      case (state_nxt_s)
         REL_PERIPH: begin
            core_n_nxt_s = 1'b1;
         end
         RUN: begin
            core_n_nxt_s   = 1'b1;
            periph_n_nxt_s = 1'b1;
            ready_nxt_s    = 1'b1;
         end
         default: begin
            core_n_nxt_s   = 1'b0;
            periph_n_nxt_s = 1'b0;
            ready_nxt_s    = 1'b0;
         end
      endcase
   end

   // Output, timeout and loss registers
   always_ff @(posedge CLKI or negedge RSTN) begin
      if (!RSTN) begin
         core_n_r   <= 1'b0;
         periph_n_r <= 1'b0;
         ready_r    <= 1'b0;
         tmo_r      <= ZERO_C;
         tflag_r    <= 1'b0;
         loss_r     <= {CNT_W{1'b0}};
      end else begin
         core_n_r   <= core_n_nxt_s;
         periph_n_r <= periph_n_nxt_s;
         ready_r    <= ready_nxt_s;
         tmo_r      <= tmo_nxt_s;
         tflag_r    <= tflag_nxt_s;
         loss_r     <= loss_nxt_s;
      end
   end

   assign RST_CORE_N   = core_n_r;
   assign RST_PERIPH_N = periph_n_r;
   assign READY        = ready_r;
   assign TIMEOUT_FLAG = tflag_r;
   assign LOSS_CNT     = loss_r;
   assign STATE        = state_r;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq (SYNC_STAGES=2, LOCK_FILT=8, CORE_DLY=4, PERIPH_DLY=6, TIMEOUT=50).
// Edge cyc=1 is the first CLKI rising edge after RSTN release; inputs change 1 time unit after an edge.
module tb_pll_rst_seq;

   logic       clki = 1'b0;
   logic       rstn = 1'b0;
   logic       lock = 1'b0;
   logic       soft_rst = 1'b0;
   logic       rst_core_n;
   logic       rst_periph_n;
   logic       ready;
   logic       timeout_flag;
   logic [7:0] loss_cnt;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_loss;

   pll_rst_seq #(
      .SYNC_STAGES(2),
      .LOCK_FILT  (8),
      .CORE_DLY   (4),
      .PERIPH_DLY (6),
      .TIMEOUT    (50),
      .CNT_W      (8)
   ) dut (
      .CLKI        (clki),
      .RSTN        (rstn),
      .LOCK        (lock),
      .SOFT_RST    (soft_rst),
      .RST_CORE_N  (rst_core_n),
      .RST_PERIPH_N(rst_periph_n),
      .READY       (ready),
      .TIMEOUT_FLAG(timeout_flag),
      .LOSS_CNT    (loss_cnt),
      .STATE       (state)
   );

   always #5 clki = ~clki;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clki);
      cyc++;
      #1;
   endtask

   task automatic step_to(input int n);
      while (cyc < n) step();
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (state !== s && n < budget) begin
         step();
         n++;
      end
      chk(tag, state, s);
   endtask

   // Holds RSTN low for a few edges, checks the reset values, then releases between edges
   task automatic do_reset();
      rstn     = 1'b0;
      lock     = 1'b0;
      soft_rst = 1'b0;
      step(); step(); step();
      chk("rst_state", state, 3'd0);
      chk("rst_core_n", rst_core_n, 1'b0);
      chk("rst_periph_n", rst_periph_n, 1'b0);
      chk("rst_ready", ready, 1'b0);
      chk("rst_tflag", timeout_flag, 1'b0);
      chk("rst_loss", loss_cnt, 8'd0);
      rstn = 1'b1;
      cyc  = 0;
   endtask

   initial begin
      #1;
      // Clean lock: LOCK rises before edge 10, lock_s sampled at 12
      do_reset();
      step_to(9);  lock = 1'b1;
      step_to(11); chk("a_wait11", state, 3'd0);
      step_to(12); chk("a_filter12", state, 3'd1);
      step_to(20); chk("a_relcore20", state, 3'd2);
      step_to(23); chk("a_core_n23", rst_core_n, 1'b0);
      step_to(24); chk("a_core_n24", rst_core_n, 1'b1);
                   chk("a_relper24", state, 3'd3);
                   chk("a_per_n24", rst_periph_n, 1'b0);
      step_to(29); chk("a_ready29", ready, 1'b0);
      step_to(30); chk("a_per_n30", rst_periph_n, 1'b1);
                   chk("a_ready30", ready, 1'b1);
                   chk("a_run30", state, 3'd4);
                   chk("a_loss30", loss_cnt, 8'd0);
                   chk("a_tflag30", timeout_flag, 1'b0);

      // Loss in RUN: LOCK low for 3 edges, outputs drop on the 3rd edge
      lock = 1'b0;
      step_to(32); chk("b_ready32", ready, 1'b1);
      step_to(33); chk("b_ready33", ready, 1'b0);
                   chk("b_core_n33", rst_core_n, 1'b0);
                   chk("b_per_n33", rst_periph_n, 1'b0);
                   chk("b_wait33", state, 3'd0);
                   chk("b_loss33", loss_cnt, 8'd1);
      lock = 1'b1;
      step_to(35); chk("b_wait35", state, 3'd0);
      step_to(36); chk("b_filter36", state, 3'd1);
      step_to(47); chk("b_core_n47", rst_core_n, 1'b0);
      step_to(48); chk("b_core_n48", rst_core_n, 1'b1);
      step_to(53); chk("b_ready53", ready, 1'b0);
      step_to(54); chk("b_ready54", ready, 1'b1);
                   chk("b_loss54", loss_cnt, 8'd1);

      // SOFT_RST from RUN with lock held: no loss, immediate re-sequence
      soft_rst = 1'b1;
      step_to(55); chk("c_wait55", state, 3'd0);
                   chk("c_ready55", ready, 1'b0);
                   chk("c_core_n55", rst_core_n, 1'b0);
                   chk("c_loss55", loss_cnt, 8'd1);
      soft_rst = 1'b0;
      step_to(56); chk("c_filter56", state, 3'd1);

      // Glitch during filter: LOCK high 5 edges, low 1, then high
      do_reset();
      step_to(9);  lock = 1'b1;
      step_to(14); lock = 1'b0;
      step_to(15); lock = 1'b1;
      step_to(16); chk("d_filter16", state, 3'd1);
      step_to(17); chk("d_wait17", state, 3'd0);
                   chk("d_loss17", loss_cnt, 8'd0);
      step_to(18); chk("d_filter18", state, 3'd1);
      step_to(25); chk("d_filter25", state, 3'd1);
      step_to(26); chk("d_relcore26", state, 3'd2);
      step_to(29); chk("d_core_n29", rst_core_n, 1'b0);
      step_to(30); chk("d_core_n30", rst_core_n, 1'b1);
      step_to(35); chk("d_ready35", ready, 1'b0);
      step_to(36); chk("d_ready36", ready, 1'b1);
                   chk("d_loss36", loss_cnt, 8'd0);

      // Timeout: flag sets at edge 50 and survives a later lock
      do_reset();
      step_to(49); chk("e_tflag49", timeout_flag, 1'b0);
      step_to(50); chk("e_tflag50", timeout_flag, 1'b1);
      step_to(60); chk("e_tflag60", timeout_flag, 1'b1);
      lock = 1'b1;
      step_to(63); chk("e_filter63", state, 3'd1);
      step_to(81); chk("e_ready81", ready, 1'b1);
                   chk("e_tflag81", timeout_flag, 1'b1);
      soft_rst = 1'b1;
      step_to(82); chk("e_tflag82", timeout_flag, 1'b0);
                   chk("e_wait82", state, 3'd0);
                   chk("e_ready82", ready, 1'b0);
      soft_rst = 1'b0;
      step_to(83); chk("e_filter83", state, 3'd1);
      step_to(101); chk("e_ready101", ready, 1'b1);

      // SOFT_RST coincident with lock loss: counted once, flag clear
      lock = 1'b0;
      step_to(103); soft_rst = 1'b1;
      step_to(104); chk("f_wait104", state, 3'd0);
                    chk("f_loss104", loss_cnt, 8'd1);
                    chk("f_tflag104", timeout_flag, 1'b0);
                    chk("f_ready104", ready, 1'b0);
      soft_rst = 1'b0;
      step_to(106); chk("f_loss106", loss_cnt, 8'd1);

      // Saturation: 300 losses from REL_CORE, LOSS_CNT sticks at 255
      do_reset();
      exp_loss = 0;
      for (int i = 0; i < 300; i++) begin
         lock = 1'b1;
         wait_state(3'd2, 40, "g_to_relcore");
         lock = 1'b0;
         wait_state(3'd0, 10, "g_to_wait");
         if (exp_loss < 255) exp_loss++;
         chk("g_loss", loss_cnt, exp_loss);
      end
      chk("g_loss_sat", loss_cnt, 8'd255);

      // Asynchronous RSTN mid-REL_PERIPH clears outputs without a clock edge
      lock = 1'b1;
      wait_state(3'd3, 40, "h_to_relper");
      chk("h_core_n", rst_core_n, 1'b1);
      chk("h_per_n", rst_periph_n, 1'b0);
      #2 rstn = 1'b0;
      #1;
      chk("h_state", state, 3'd0);
      chk("h_core_n_rst", rst_core_n, 1'b0);
      chk("h_per_n_rst", rst_periph_n, 1'b0);
      chk("h_ready_rst", ready, 1'b0);
      chk("h_tflag_rst", timeout_flag, 1'b0);
      chk("h_loss_rst", loss_cnt, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
